// File: rtl/gpio_event_monitor.sv
// gpio_event_monitor
//
// Watches a GPIO output bus. It waits for the design enable, then runs a fixed
// observation window. During the window every masked pin change is logged,
// together with a timestamp, into a first-word fall-through FIFO. At the end
// of the window the monitor declares pass or fail. It also fails with a
// timeout if the enable never arrives.
//
// Ports
//   clk       system clock
//   nrst      asynchronous active-low reset
//   en        design enable; starts the run and keeps it going
//   gpio_in   monitored pins (asynchronous to clk)
//   mask      1 = bit is monitored; sampled every cycle
//   rd_en     pop the FIFO head
//   rd_valid  FIFO not empty
//   rd_data   {timestamp, synchronised gpio value} at the FIFO head
//   ev_count  accepted events in this run; saturates at 0xFFFF
//   overflow  sticky: an event was dropped because the FIFO was full
//   busy      observation window in progress
//   done      run finished (pass or fail)
//   pass      run finished and passed
//   timeout   sticky: the enable never arrived within TIMEOUT_CYCLES

`timescale 1ns/1ps

module gpio_event_monitor #(
  parameter int WIDTH          = 34,
  parameter int DEPTH          = 8,
  parameter int TS_W           = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int RUN_CYCLES     = 10000,
  parameter int MIN_EVENTS     = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      gpio_in,
  input  logic [WIDTH-1:0]      mask,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [TS_W+WIDTH-1:0] rd_data,
  output logic [15:0]           ev_count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout
);

  localparam int AW   = $clog2(DEPTH);
  localparam int DW   = TS_W + WIDTH;
  // The run counter must hold RUN_CYCLES and be wide enough to supply the
  // timestamp slice.
  localparam int RC_W = (TS_W > $clog2(RUN_CYCLES) + 1) ? TS_W : $clog2(RUN_CYCLES) + 1;
  localparam int IC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [AW:0]     PTR_ONE  = 1;
  localparam logic [RC_W-1:0] RC_ONE   = 1;
  localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RUN_CYCLES - 1);
  localparam logic [IC_W-1:0] IC_ONE   = 1;
  localparam logic [IC_W-1:0] IC_LAST  = IC_W'(TIMEOUT_CYCLES - 1);
  localparam bit              TMO_ON   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Input synchroniser and change detection
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] gs;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] change;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gs = sync_q[SYNC_STAGES-1];

  // prev tracks gs every cycle, so on RUN entry it already holds the value
  // seen in the last IDLE cycle and no spurious first event is logged.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) prev <= '0;
    else       prev <= gs;
  end

  assign change = (gs ^ prev) & mask;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DW-1:0]     mem [DEPTH];
  logic              empty, full;
  logic              start, push, pop, accept, drop;
  logic [RC_W-1:0]   run_cnt;
  logic [IC_W-1:0]   idle_cnt;
  logic              started;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign start  = (state == S_IDLE) && en;
  assign push   = (state == S_RUN) && (|change);
  assign pop    = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the head is being read.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and rd_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= {run_cnt[TS_W-1:0], gs};
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // ---------------------------------------------------------------------------
  // Run bookkeeping
  // ---------------------------------------------------------------------------
  logic        last_cycle;
  logic        timeout_hit;
  logic        idle_counting;
  logic [15:0] ev_after;
  logic        ovf_after;
  logic        pass_ok;

  assign last_cycle    = (run_cnt == RC_LAST);
  assign idle_counting = TMO_ON && (state == S_IDLE) && !en && !started && !timeout;
  assign timeout_hit   = idle_counting && (idle_cnt == IC_LAST);

  // The verdict includes an event accepted or dropped in the final cycle.
  assign ev_after  = (accept && ev_count != 16'hFFFF) ? ev_count + 16'd1 : ev_count;
  assign ovf_after = overflow || drop;
  assign pass_ok   = (32'(ev_after) >= 32'(MIN_EVENTS)) && !ovf_after;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      run_cnt  <= '0;
      idle_cnt <= '0;
      started  <= 1'b0;
      timeout  <= 1'b0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (start)                    run_cnt <= '0;
      else if (state == S_RUN)      run_cnt <= run_cnt + RC_ONE;

      // The idle counter only runs before the first RUN entry and is never
      // cleared by an abort.
      if (idle_counting)            idle_cnt <= idle_cnt + IC_ONE;
      if (start)                    started  <= 1'b1;
      if (timeout_hit)              timeout  <= 1'b1;

      if (start)                    ev_count <= '0;
      else                          ev_count <= ev_after;

      if (start)                    overflow <= 1'b0;
      else                          overflow <= ovf_after;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first means every path drives state_next,
  // so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (en)               state_next = S_RUN;
        else if (timeout_hit) state_next = S_FAIL;
      end
      S_RUN: begin
        if (!en)              state_next = S_IDLE;
        else if (last_cycle)  state_next = pass_ok ? S_PASS : S_FAIL;
      end
      S_PASS, S_FAIL: begin
        if (!en)              state_next = S_IDLE;
      end
      default:                state_next = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_PASS) || (state == S_FAIL);
  assign pass = (state == S_PASS);

endmodule

// File: tb/tb_gpio_event_monitor.sv
`timescale 1ns/1ps

module tb_gpio_event_monitor;

  localparam int WIDTH  = 34;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 16;
  localparam int SS     = 2;
  localparam int RUN    = 400;
  localparam int MIN_EV = 1;
  localparam int TMO    = 500;
  localparam int DW     = TS_W + WIDTH;

  logic             clk = 1'b0;
  logic             nrst;
  logic             en;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] mask;
  logic             rd_en;
  logic             rd_valid;
  logic [DW-1:0]    rd_data;
  logic [15:0]      ev_count;
  logic             overflow, busy, done, pass, timeout;

  gpio_event_monitor #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W), .SYNC_STAGES(SS),
    .RUN_CYCLES(RUN), .MIN_EVENTS(MIN_EV), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .nrst(nrst), .en(en), .gpio_in(gpio_in), .mask(mask),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .ev_count(ev_count), .overflow(overflow), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  int            rc;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_head;

  typedef struct {
    logic [WIDTH-1:0] gpio;
    logic [WIDTH-1:0] msk;
    bit               ev;
    logic [15:0]      cnt;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; stimulus and sampling happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    rc++;
    @(negedge clk);
  endtask

  // Raise en; the next rising edge enters RUN with run counter 0.
  task automatic start_run();
    sb.delete();
    en = 1'b1;
    tick();
    rc = 0;
  endtask

  task automatic end_run();
    en = 1'b0;
    tick();
  endtask

  // A value driven now reaches gs SS edges later, which is its timestamp.
  task automatic drive(input logic [WIDTH-1:0] v, input bit expect_ev);
    gpio_in = v;
    if (expect_ev) sb.push_back({TS_W'(rc + SS), v});
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic drain(input string name);
    logic [DW-1:0] e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, " valid"}, 64'(rd_valid), 64'd1);
      check({name, " data"}, 64'(rd_data), 64'(e));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    check({name, " empty"}, 64'(rd_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{gpio: 34'h0_0000_0001, msk: '1,             ev: 1'b1, cnt: 16'd1};
    tbl[1] = '{gpio: 34'h0_0000_0003, msk: 34'h0_0000_0001, ev: 1'b0, cnt: 16'd1};
    tbl[2] = '{gpio: 34'h0_0000_0002, msk: 34'h0_0000_0001, ev: 1'b1, cnt: 16'd2};
    tbl[3] = '{gpio: 34'h0_0000_0002, msk: '1,             ev: 1'b0, cnt: 16'd2};
    tbl[4] = '{gpio: 34'h2_0000_0002, msk: 34'h2_0000_0000, ev: 1'b1, cnt: 16'd3};
    tbl[5] = '{gpio: 34'h0_0000_0000, msk: 34'h0_0000_0000, ev: 1'b0, cnt: 16'd3};
    tbl[6] = '{gpio: 34'h3_0000_0000, msk: 34'h1_0000_0000, ev: 1'b1, cnt: 16'd4};

    nrst = 1'b0; en = 1'b0; rd_en = 1'b0; gpio_in = '0; mask = '1; rc = 0;

    // Reset state
    #12;
    check("rst busy",     64'(busy),     64'd0);
    check("rst done",     64'(done),     64'd0);
    check("rst pass",     64'(pass),     64'd0);
    check("rst timeout",  64'(timeout),  64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst ev_count", 64'(ev_count), 64'd0);
    check("rst rd_valid", 64'(rd_valid), 64'd0);
    check("rst rd_data",  64'(rd_data),  64'd0);
    @(negedge clk);
    nrst = 1'b1;

    // 1: static pins for the whole window -> fail with no events
    repeat (50) tick();
    start_run();
    check("t1 busy", 64'(busy), 64'd1);
    wait_done(RUN + 20);
    check("t1 window length", 64'(rc), 64'(RUN));
    check("t1 done",     64'(done),     64'd1);
    check("t1 pass",     64'(pass),     64'd0);
    check("t1 ev_count", 64'(ev_count), 64'd0);
    check("t1 rd_valid", 64'(rd_valid), 64'd0);
    end_run();
    check("t1 idle done", 64'(done), 64'd0);
    // Timeout counter must stay frozen after the first run.
    repeat (TMO + 100) tick();
    check("no timeout after run", 64'(timeout), 64'd0);
    check("no timeout done",      64'(done),    64'd0);

    // 2: two toggles of bit 0 at run cycles 100 and 200
    start_run();
    while (rc < 100 - SS) tick();
    drive(34'h1, 1'b1);
    while (rc < 200 - SS) tick();
    drive(34'h0, 1'b1);
    repeat (SS + 2) tick();
    check("t2 ev_count", 64'(ev_count), 64'd2);
    wait_done(RUN);
    check("t2 done", 64'(done), 64'd1);
    check("t2 pass", 64'(pass), 64'd1);
    drain("t2");
    end_run();

    // Mask table: each vector held four cycles so the mask covers the arrival
    start_run();
    for (int i = 0; i < 7; i++) begin
      mask = tbl[i].msk;
      drive(tbl[i].gpio, tbl[i].ev);
      repeat (4) tick();
      check($sformatf("tbl[%0d] ev_count", i), 64'(ev_count), 64'(tbl[i].cnt));
    end
    mask = '1;
    wait_done(RUN);
    check("tbl pass", 64'(pass), 64'd1);
    drain("tbl");
    end_run();

    // 3: change every cycle for 12 cycles, no reads -> overflow
    start_run();
    for (int i = 0; i < 12; i++) begin
      drive(WIDTH'(i + 1), i < DEPTH);
      tick();
    end
    repeat (SS + 2) tick();
    check("t3 ev_count", 64'(ev_count), 64'd8);
    check("t3 overflow", 64'(overflow), 64'd1);
    wait_done(RUN);
    check("t3 done", 64'(done), 64'd1);
    check("t3 pass", 64'(pass), 64'd0);
    drain("t3");
    end_run();

    // 4: full FIFO, pop in the same cycle as a new push
    start_run();
    for (int i = 0; i < DEPTH; i++) begin
      drive(WIDTH'(34'h100 + i), 1'b1);
      tick();
    end
    repeat (SS + 2) tick();
    check("t4 fill ev_count", 64'(ev_count), 64'd8);
    check("t4 fill overflow", 64'(overflow), 64'd0);
    drive(34'h2_0000_0000, 1'b1);
    repeat (SS) tick();
    exp_head = sb.pop_front();
    check("t4 head before", 64'(rd_data), 64'(exp_head));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t4 ev_count", 64'(ev_count), 64'd9);
    check("t4 overflow", 64'(overflow), 64'd0);
    check("t4 head after", 64'(rd_data), 64'(sb[0]));
    wait_done(RUN);
    check("t4 pass", 64'(pass), 64'd1);
    drain("t4");
    end_run();

    // 6: abort after 3 events; read on empty beforehand must be ignored
    start_run();
    rd_en = 1'b1;
    repeat (2) tick();
    rd_en = 1'b0;
    check("t6 empty read", 64'(rd_valid), 64'd0);
    drive(34'h5, 1'b1); tick();
    drive(34'hA, 1'b1); tick();
    drive(34'hF, 1'b1); tick();
    repeat (SS + 2) tick();
    check("t6 ev_count", 64'(ev_count), 64'd3);
    end_run();
    check("t6 abort busy", 64'(busy), 64'd0);
    check("t6 abort done", 64'(done), 64'd0);
    check("t6 abort pass", 64'(pass), 64'd0);
    for (int i = 0; i < 2; i++) begin
      exp_head = sb.pop_front();
      check($sformatf("t6 entry%0d", i), 64'(rd_data), 64'(exp_head));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    check("t6 last entry kept", 64'(rd_valid), 64'd1);
    check("t6 last entry data", 64'(rd_data), 64'(sb[0]));
    start_run();
    check("t6 restart rd_valid", 64'(rd_valid), 64'd0);
    check("t6 restart ev_count", 64'(ev_count), 64'd0);
    check("t6 restart busy",     64'(busy),     64'd1);

    // Asynchronous reset while busy, without a clock edge
    #2;
    nrst = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    en = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    rc = 0;

    // 5: en never arrives -> timeout after TMO idle cycles
    while (!done && rc < TMO + 200) tick();
    check("t5 timeout cycle", 64'(rc), 64'(TMO));
    check("t5 done",    64'(done),    64'd1);
    check("t5 timeout", 64'(timeout), 64'd1);
    check("t5 pass",    64'(pass),    64'd0);
    tick();
    check("t5 sticky timeout", 64'(timeout), 64'd1);
    start_run();
    check("t5 run busy",    64'(busy),    64'd1);
    check("t5 run timeout", 64'(timeout), 64'd1);
    end_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_event_monitor.md
Name: gpio_event_monitor

Overview:
- Parametrised on-chip successor to the team bench monitor. It waits for the design enable, then runs a fixed observation window.
- During the window it logs every masked GPIO change, with a timestamp, into a FIFO.
- At the end it declares pass or fail; it fails with a timeout if enable never arrives.
- It sits beside the team wrapper and reads its GPIO output bus. The management core or the bench drains the FIFO and reads the status.

Parameters:
- WIDTH, 34, number of monitored GPIO bits.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TS_W, 16, timestamp width.
- SYNC_STAGES, 2, input synchroniser flops; at least 1.
- RUN_CYCLES, 10000, length of the observation window in clk cycles.
- MIN_EVENTS, 1, accepted events required to pass.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed before timeout; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  design enable; starts and keeps the run
- gpio_in  in  WIDTH  monitored pins (asynchronous)
- mask  in  WIDTH  1 = bit is monitored; sampled every cycle
- rd_en  in  1  pop the FIFO head
- rd_valid  out  1  FIFO not empty
- rd_data  out  TS_W+WIDTH  {timestamp, synchronised gpio value} at the head (first-word fall-through)
- ev_count  out  16  accepted events this run; saturates at 0xFFFF
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- busy  out  1  state is RUN
- done  out  1  state is PASS or FAIL
- pass  out  1  state is PASS
- timeout  out  1  sticky: the idle timeout fired

Behaviour:
- Reset: the asynchronous reset takes effect immediately. All outputs are 0, state is IDLE, FIFO is empty, the synchroniser is cleared and all counters are 0.
- Synchroniser: gpio_in passes through SYNC_STAGES flops, giving gs. prev holds gs from the previous cycle.
- change = (gs ^ prev) & mask.
- States:
  - IDLE:
    - en=1 → RUN. On entry: FIFO cleared, ev_count=0, overflow=0, run counter=0, and prev loaded from gs so no spurious first event is logged.
    - While en=0 and timeout not yet fired, the idle counter increments. When it reaches TIMEOUT_CYCLES (nonzero) → FAIL with timeout=1.
  - RUN:
    - Run counter increments every cycle.
    - change≠0 → push {run_counter[TS_W-1:0], gs}. The timestamp wraps modulo 2^TS_W.
    - Run counter reaching RUN_CYCLES-1 → PASS if ev_count ≥ MIN_EVENTS and overflow=0, else → FAIL. An event in that last cycle is still logged.
    - en=0 → IDLE (abort). done and pass stay 0; FIFO contents are retained; the idle counter is not restarted.
  - PASS / FAIL: hold. en=0 → IDLE. FIFO remains readable.
- The timeout counter runs only before the first RUN entry. Once timeout=1 it stays 1 until nrst.
- Latency: a pin change settled before edge k is visible in gs after SYNC_STAGES edges. The entry shows rd_valid=1 one cycle later.
- FIFO rules:
  - Push when full and no pop: event dropped, overflow=1, ev_count unchanged.
  - Push and pop in the same cycle when full: both succeed; occupancy is unchanged.
  - rd_en while empty: ignored; pointers do not move.
  - Pointers wrap modulo DEPTH. Full/empty are determined with an extra pointer bit.
- ev_count counts accepted pushes only.
- mask changes take effect the cycle they are sampled. Unmasked bits are still stored in rd_data.

Test Plan:
1. nrst=0 then released; en=1 after 50 cycles; gpio_in static for the whole window → RUN_CYCLES later done=1, pass=0, ev_count=0 (MIN_EVENTS=1).
2. en=1; toggle gpio_in[0] at run cycles 100 and 200 → two entries: timestamps 100 and 200 (±0, relative to synchronised arrival), data bit0 = 1 then 0. pass=1 at the end of the window.
3. DEPTH=8, mask=all ones; gpio_in changes every cycle for 12 cycles with no reads → ev_count=8, overflow=1. At the end, pass=0 and done=1.
4. FIFO full; rd_en=1 in the same cycle as a new change → occupancy stays 8, head advances, overflow stays 0.
5. TIMEOUT_CYCLES=500; en held at 0 → at idle cycle 500, timeout=1, done=1, pass=0. A later en=1 enters RUN, but timeout stays 1.
6. en drops mid-RUN after 3 events → busy=0, done=0, the 3 entries stay readable. A new en=1 clears the FIFO and ev_count.
